// File: rtl/pzbcm_async_handshake_arbiter_if.sv
// pzbcm_async_handshake_arbiter_if: client request bundle plus crossing-side handshake for pzbcm_async_handshake_arbiter
`timescale 1ns/1ps
interface pzbcm_async_handshake_arbiter_if #(
  parameter int REQUESTERS = 4,
  parameter int WIDTH = 8,
  parameter type TYPE = logic [WIDTH-1:0]
);
  logic [REQUESTERS-1:0] is_valid;
  logic [REQUESTERS-1:0] os_ready;
  TYPE is_data [REQUESTERS];
  logic os_hs_valid;
  logic is_hs_ready;
  TYPE os_hs_data;
  logic [$clog2(REQUESTERS)-1:0] os_grant_id;
  logic os_busy;
  modport master (
    input is_valid, is_data, is_hs_ready,
    output os_ready, os_hs_valid, os_hs_data, os_grant_id, os_busy
  );
  modport slave (
    output is_valid, is_data, is_hs_ready,
    input os_ready, os_hs_valid, os_hs_data, os_grant_id, os_busy
  );
endinterface

// File: rtl/pzbcm_async_handshake_arbiter.sv
// pzbcm_async_handshake_arbiter: round-robin share of one pzbcm_async_handshake source port.
// Optional sticky stall flag enabled by PZBCM_ASYNC_HANDSHAKE_ARBITER_TIMEOUT_EN.
`timescale 1ns/1ps
module pzbcm_async_handshake_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int WIDTH = 8,
  parameter type TYPE = logic [WIDTH-1:0],
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic is_clk,
  input  logic is_rst_n,
  pzbcm_async_handshake_arbiter_if.master bus,
  input  logic is_timeout_clear,
  output logic os_timeout
);
  localparam int IW = $clog2(REQUESTERS);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, gid_q, gid_d, g;
  logic found, grant;
  // Lowest offset from the pointer wins, so iterate downward and let later hits override.
  always_comb begin
    g = ptr_q;
    found = 1'b0;
    for (int i = REQUESTERS - 1; i >= 0; i--) begin
      if (bus.is_valid[(int'(ptr_q) + i) % REQUESTERS]) begin
        g = IW'((int'(ptr_q) + i) % REQUESTERS);
        found = 1'b1;
      end
    end
  end
  assign grant = state_q == IDLE && bus.is_hs_ready && found;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    gid_d = gid_q;
    bus.os_hs_valid = state_q == IDLE && found;
    bus.os_hs_data = bus.is_data[g];
    bus.os_ready = grant ? REQUESTERS'(1) << g : '0;
    bus.os_busy = state_q == BUSY;
    bus.os_grant_id = gid_q;
    if (grant) begin
      state_d = BUSY;
      ptr_d = g == IW'(REQUESTERS - 1) ? '0 : g + 1'b1;
      gid_d = g;
    end else if (state_q == BUSY && bus.is_hs_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge is_clk or negedge is_rst_n) begin
    if (!is_rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      gid_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      gid_q <= gid_d;
    end
  end
`ifdef PZBCM_ASYNC_HANDSHAKE_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic timeout_q, timeout_d, hit;
  // Count BUSY cycles; the flag fires once when the count reaches the limit and never aborts the wait.
  always_comb begin
    hit = state_q == BUSY && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    cnt_d = state_q == IDLE ? '0 : cnt_q == CW'(TIMEOUT_CYCLES) ? cnt_q : cnt_q + 1'b1;
    timeout_d = hit | (timeout_q & ~is_timeout_clear);
  end
  always_ff @(posedge is_clk or negedge is_rst_n) begin
    if (!is_rst_n) begin
      cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign os_timeout = timeout_q;
`else
  logic unused_clear;
  assign unused_clear = is_timeout_clear;
  assign os_timeout = 1'b0;
`endif
endmodule
